// File: rtl/bambu_mem_pkg.sv
// Shared types and helpers for the Bambu memory responder: channel state
// encoding, access-size decode and byte-lane mask generation.
package bambu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } chan_state_t;

    // Legal sizes are 8*2^k bits up to data_w; anything else becomes a full-width access.
    function automatic int unsigned size_bytes(input int unsigned size_bits,
                                               input int unsigned data_w);
        int unsigned n;
        n = data_w / 8;
        for (int unsigned k = 1; k <= data_w / 8; k = k * 2) begin
            if (size_bits == 8 * k) n = k;
        end
        return n;
    endfunction

    function automatic logic [127:0] lane_mask(input int unsigned nbytes);
        logic [127:0] m;
        m = '0;
        for (int unsigned i = 0; i < 128; i++) m[i] = (i < nbytes);
        return m;
    endfunction

endpackage

// File: rtl/bambu_mem_responder_if.sv
// Master-side memory bus of a Bambu accelerator, all channels packed.
interface bambu_mem_responder_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned SIZE_W   = 8
);
    logic [CHANNELS-1:0]        Mout_oe_ram;
    logic [CHANNELS-1:0]        Mout_we_ram;
    logic [CHANNELS*ADDR_W-1:0] Mout_addr_ram;
    logic [CHANNELS*DATA_W-1:0] Mout_Wdata_ram;
    logic [CHANNELS*SIZE_W-1:0] Mout_data_ram_size;
    logic [CHANNELS*DATA_W-1:0] M_Rdata_ram;
    logic [CHANNELS-1:0]        M_DataRdy;

    modport master (
        output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        input  M_Rdata_ram, M_DataRdy
    );

    modport slave (
        input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        output M_Rdata_ram, M_DataRdy
    );
endinterface

// File: rtl/bambu_mem_channel_ctrl.sv
// Per-channel request FSM: capture, latency counter, registered read data, DataRdy.
// Optional BAMBU_MEM_RESPONDER_STATS_EN adds saturating read/write completion counters.
module bambu_mem_channel_ctrl
    import bambu_mem_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned READ_DELAY  = 2,
    parameter int unsigned WRITE_DELAY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              oe,
    input  logic              we,
    input  logic [DATA_W-1:0] rd_sample,
    output logic              capture,
    output logic              data_rdy,
    output logic [DATA_W-1:0] rdata
`ifdef BAMBU_MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`endif
);
    localparam int unsigned MAXD  = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
    localparam int unsigned CNT_W = (MAXD < 2) ? 1 : $clog2(MAXD);

    chan_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic              is_write;
    logic [DATA_W-1:0] rd_buf;

    // Address/size/wdata are consumed at capture by the top (commit and read sample),
    // so only the access type and the sampled read data need to be held here.
    assign capture  = reset && (state == IDLE) && (oe || we);
    assign data_rdy = (state == RESP);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            is_write <= 1'b0;
            rd_buf   <= '0;
            rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (oe || we) begin
                        is_write <= we;
                        rd_buf   <= rd_sample;
                        if (we) begin
                            if (WRITE_DELAY == 1) state <= RESP;
                            else begin
                                cnt   <= CNT_W'(WRITE_DELAY - 1);
                                state <= WAIT;
                            end
                        end else if (READ_DELAY == 1) begin
                            rdata <= rd_sample;
                            state <= RESP;
                        end else begin
                            cnt   <= CNT_W'(READ_DELAY - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                        if (!is_write) rdata <= rd_buf;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BAMBU_MEM_RESPONDER_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == RESP) begin
            if (is_write) begin
                if (wr_count != '1) wr_count <= wr_count + 32'd1;
            end else if (rd_count != '1) begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: rtl/bambu_mem_responder.sv
// Byte-addressed memory responder for a Bambu accelerator's master bus.
// Optional BAMBU_MEM_RESPONDER_STATS_EN exposes per-channel rd_count/wr_count.
module bambu_mem_responder
    import bambu_mem_pkg::*;
#(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SIZE_W      = 8,
    parameter int unsigned MEM_BYTES   = 1024,
    parameter int unsigned READ_DELAY  = 2,
    parameter int unsigned WRITE_DELAY = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    bambu_mem_responder_if.slave bus,
    input  logic                 init_we,
    input  logic [ADDR_W-1:0]    init_addr,
    input  logic [7:0]           init_data,
    output logic                 addr_err
`ifdef BAMBU_MEM_RESPONDER_STATS_EN
    ,
    output logic [CHANNELS*32-1:0] rd_count,
    output logic [CHANNELS*32-1:0] wr_count
`endif
);
    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned IDX_W = (MEM_BYTES < 2) ? 1 : $clog2(MEM_BYTES);

    logic [7:0]        mem [MEM_BYTES];
    logic [CHANNELS-1:0] capture;
    logic [CHANNELS-1:0] data_rdy;
    logic [CHANNELS-1:0] range_err;
    logic [DATA_W-1:0] rd_sample [CHANNELS];
    logic [DATA_W-1:0] rdata_ch  [CHANNELS];
    logic [LANES-1:0]  wr_lane   [CHANNELS];
    logic [IDX_W-1:0]  byte_idx  [CHANNELS][LANES];
    logic              init_ok;

    assign init_ok = ({1'b0, init_addr} < (ADDR_W+1)'(MEM_BYTES));

    always_comb begin
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
        logic [127:0]      mask;
        logic [ADDR_W:0]   baddr;
        logic              in_range;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            addr         = bus.Mout_addr_ram[c*ADDR_W +: ADDR_W];
            size         = bus.Mout_data_ram_size[c*SIZE_W +: SIZE_W];
            mask         = lane_mask(size_bytes(32'(size), DATA_W));
            range_err[c] = 1'b0;
            rd_sample[c] = '0;
            wr_lane[c]   = '0;
            for (int unsigned b = 0; b < LANES; b++) begin
                baddr          = {1'b0, addr} + (ADDR_W+1)'(b);
                in_range       = (baddr < (ADDR_W+1)'(MEM_BYTES));
                byte_idx[c][b] = baddr[IDX_W-1:0];
                if (mask[b] && !in_range) range_err[c] = 1'b1;
                if (mask[b] && in_range) begin
                    rd_sample[c][8*b +: 8] = mem[baddr[IDX_W-1:0]];
                    wr_lane[c][b]          = capture[c] && bus.Mout_we_ram[c];
                end
            end
        end
    end

    // Later assignments win: init first, then channels in ascending index.
    always_ff @(posedge clock) begin
        if (init_we && init_ok) mem[init_addr[IDX_W-1:0]] <= init_data;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            for (int unsigned b = 0; b < LANES; b++) begin
                if (wr_lane[c][b])
                    mem[byte_idx[c][b]] <= bus.Mout_Wdata_ram[c*DATA_W + 8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) addr_err <= 1'b0;
        else if (|(capture & range_err) || (init_we && !init_ok)) addr_err <= 1'b1;
    end

`ifdef BAMBU_MEM_RESPONDER_STATS_EN
    logic [31:0] rd_count_ch [CHANNELS];
    logic [31:0] wr_count_ch [CHANNELS];
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        bambu_mem_channel_ctrl #(
            .DATA_W      (DATA_W),
            .READ_DELAY  (READ_DELAY),
            .WRITE_DELAY (WRITE_DELAY)
        ) u_ctrl (
            .clock     (clock),
            .reset     (reset),
            .oe        (bus.Mout_oe_ram[c]),
            .we        (bus.Mout_we_ram[c]),
            .rd_sample (rd_sample[c]),
            .capture   (capture[c]),
            .data_rdy  (data_rdy[c]),
            .rdata     (rdata_ch[c])
`ifdef BAMBU_MEM_RESPONDER_STATS_EN
            ,
            .rd_count  (rd_count_ch[c]),
            .wr_count  (wr_count_ch[c])
`endif
        );
    end

    always_comb begin
        bus.M_DataRdy = data_rdy;
        for (int unsigned c = 0; c < CHANNELS; c++)
            bus.M_Rdata_ram[c*DATA_W +: DATA_W] = rdata_ch[c];
    end

`ifdef BAMBU_MEM_RESPONDER_STATS_EN
    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            rd_count[c*32 +: 32] = rd_count_ch[c];
            wr_count[c*32 +: 32] = wr_count_ch[c];
        end
    end
`endif

endmodule
